rx_word_scheduler: RTL and testbench
====================================

RX_WORD_SCHEDULER -- requirements
Module: rx_word_scheduler

Interface
REQ-001 Parameter: TIMEOUT_W, 16, width of the idle-timeout counter and of timeout_cycles.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  1 = new FIFO pops allowed.
REQ-005 fifo_empty  input  1  RX byte FIFO empty flag.
REQ-006 fifo_full  input  1  RX byte FIFO full flag.
REQ-007 fifo_rd  output  1  one-cycle pop strobe to the RX byte FIFO.
REQ-008 fifo_data  input  8  FIFO read data, valid the cycle after fifo_rd.
REQ-009 timeout_cycles  input  TIMEOUT_W  idle cycles before a partial word is flushed; 0 = timeout disabled.
REQ-010 word_data  output  32  assembled word; byte 0 in [7:0].
REQ-011 word_bytes  output  3  number of valid bytes in word_data, 1..4.
REQ-012 word_valid  output  1  word available to the consumer.
REQ-013 word_ready  input  1  consumer accepts the word.
REQ-014 overrun  output  1  sticky flag: FIFO full while a word is stalled.
REQ-015 clear_overrun  input  1  synchronous clear of overrun.

Function
REQ-016 The FSM SHALL have states IDLE, LATCH and SEND, plus an internal byte count cnt (0..4) and an idle timer.
REQ-017 IDLE: if enable=1, fifo_empty=0 and cnt<4, the block SHALL drive fifo_rd=1 for exactly one cycle and enter LATCH.
REQ-018 fifo_rd SHALL never be asserted outside IDLE, and never on two consecutive cycles.
REQ-019 LATCH: the block SHALL store fifo_data into byte lane cnt, increment cnt and clear the timer.
REQ-020 LATCH exit: if the incremented cnt is 4, the FSM SHALL enter SEND; otherwise it SHALL return to IDLE.
REQ-021 Timer: in IDLE with cnt>0 and no pop issued, the timer SHALL increment once per cycle, saturating at all-ones.
REQ-022 Timeout flush: in IDLE, if timeout_cycles!=0, cnt>0, no pop is issued and timer==timeout_cycles-1, the FSM SHALL enter SEND with the partial word.
REQ-023 Pop priority: an available byte SHALL take priority over a timeout in the same cycle.
REQ-024 SEND: word_valid SHALL be 1; word_data and word_bytes SHALL equal the latched lanes and cnt; unused lanes SHALL be 0.
REQ-025 word_data and word_bytes SHALL remain stable while word_valid=1 and word_ready=0.
REQ-026 Handshake: word_valid=1 and word_ready=1 on a rising edge completes the transfer.
REQ-027 On handshake: word_valid SHALL drop the next cycle, cnt, lanes and timer SHALL clear, and the FSM SHALL enter IDLE.
REQ-028 Pop latency: a pop SHALL occur no earlier than the cycle after the handshake, so at most one pop per 2 cycles.
REQ-029 word_ready while word_valid=0 SHALL be ignored.
REQ-030 enable=0 SHALL block new pops only; an in-flight LATCH completes, the timer keeps running and a pending SEND proceeds.
REQ-031 overrun SHALL be set on any cycle with word_valid=1, word_ready=0 and fifo_full=1.
REQ-032 clear_overrun=1 SHALL clear overrun, except that set wins when both occur in the same cycle.
REQ-033 A change of timeout_cycles SHALL take effect on the next cycle's comparison.

Reset
REQ-034 rst=0 SHALL immediately force FSM=IDLE, cnt=0, timer=0 and all lanes=0.
REQ-035 rst=0 SHALL immediately force outputs fifo_rd=0, word_valid=0, word_data=0, word_bytes=0 and overrun=0.
REQ-036 Reset asserted mid-word or mid-SEND SHALL discard the partial or pending word; no word_valid pulse follows reset release.

Verification
REQ-037 Full word: FIFO bytes 0x11,0x22,0x33,0x44; enable=1; word_ready=1 -> word_data=0x44332211, word_bytes=4, one word_valid cycle, exactly 4 fifo_rd pulses.
REQ-038 Timeout: timeout_cycles=10; bytes 0xAA,0xBB then FIFO stays empty -> word_data=0x0000BBAA, word_bytes=2, word_valid exactly 10 cycles after the second LATCH.
REQ-039 Backpressure/overrun: word_ready=0 for 20 cycles after a full word; fifo_full=1 at cycle 5 -> data held stable, overrun=1 until clear_overrun; simultaneous set and clear leaves overrun=1.
REQ-040 Timeout disabled: timeout_cycles=0; one byte 0x5A, then empty for 1000 cycles -> no word_valid; a further 3 bytes yield word_data=0x......5A, word_bytes=4.
REQ-041 Enable gating: enable=0 with FIFO non-empty -> no fifo_rd; re-enable -> pops resume; a pending SEND completes during enable=0.
REQ-042 Reset mid-operation: rst=0 after 3 bytes latched -> all outputs 0 immediately; after release, 4 new bytes form a clean word with no stale lanes.

Source files
------------

// File: rtl/rx_word_scheduler.sv
// rx_word_scheduler
//   Pops bytes from an RX byte FIFO and packs them little-endian into 32-bit
//   words. A word goes to the consumer when four bytes have been collected,
//   or when a partial word has sat idle for timeout_cycles cycles.
//
// Ports
//   clk, rst             clock (rising edge); asynchronous active-low reset
//   enable               1 = new FIFO pops allowed
//   fifo_empty/full      RX byte FIFO status
//   fifo_rd              one-cycle pop strobe (issued from IDLE only)
//   fifo_data            FIFO read data, valid the cycle after fifo_rd
//   timeout_cycles       idle cycles before a partial word is flushed, 0 = off
//   word_data/bytes      assembled word (byte 0 in [7:0]) and valid byte count
//   word_valid/ready     word handshake to the consumer
//   overrun              sticky: FIFO full while a word is stalled
//   clear_overrun        synchronous clear of overrun (a set in the same cycle wins)
//
// state | meaning
// IDLE  | pop a byte if allowed, otherwise run the idle timer
// LATCH | capture fifo_data into lane cnt
// SEND  | present the word until the consumer accepts it

module rx_word_scheduler #(
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic                 fifo_full,
    output logic                 fifo_rd,
    input  logic [7:0]           fifo_data,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    output logic [31:0]          word_data,
    output logic [2:0]           word_bytes,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic                 overrun,
    input  logic                 clear_overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [31:0]            data_q, data_d;
    logic [TIMEOUT_W-1:0]   timer_q, timer_d;
    logic                   overrun_q, overrun_d;
    logic                   pop;
    logic [TIMEOUT_W-1:0]   timeout_m1;

    assign timeout_m1 = timeout_cycles - TIMEOUT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        timer_d = timer_q;
        pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                pop = enable && !fifo_empty && (cnt_q < 3'd4);
                if (pop) begin
                    state_d = LATCH;
                end else if (cnt_q != 3'd0) begin
                    if (timer_q != '1) begin
                        timer_d = timer_q + TIMEOUT_W'(1);
                    end
                    // An available byte always wins over the flush (pop checked first).
                    if ((timeout_cycles != '0) && (timer_q == timeout_m1)) begin
                        state_d = SEND;
                    end
                end
            end
            LATCH: begin
                case (cnt_q[1:0])
                    2'd0:    data_d[7:0]   = fifo_data;
                    2'd1:    data_d[15:8]  = fifo_data;
                    2'd2:    data_d[23:16] = fifo_data;
                    default: data_d[31:24] = fifo_data;
                endcase
                cnt_d   = cnt_q + 3'd1;
                timer_d = '0;
                state_d = (cnt_d == 3'd4) ? SEND : IDLE;
            end
            SEND: begin
                if (word_ready) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                    data_d  = 32'd0;
                    timer_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        overrun_d = overrun_q;
        if ((state_q == SEND) && !word_ready && fifo_full) begin
            overrun_d = 1'b1;
        end else if (clear_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            data_q    <= 32'd0;
            timer_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            timer_q   <= timer_d;
            overrun_q <= overrun_d;
        end
    end

    // pop is combinational from IDLE; gate with rst so no strobe escapes during reset.
    assign fifo_rd    = pop && rst;
    assign word_valid = (state_q == SEND);
    assign word_data  = data_q;
    assign word_bytes = cnt_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_rx_word_scheduler.sv
// Directed testbench for rx_word_scheduler with a small byte-FIFO model.

module tb_rx_word_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_rd;
    logic [7:0]  fifo_data = 8'h00;
    logic [15:0] timeout_cycles;
    logic [31:0] word_data;
    logic [2:0]  word_bytes;
    logic        word_valid;
    logic        word_ready;
    logic        overrun;
    logic        clear_overrun;

    int checks = 0;
    int errors = 0;

    logic [7:0] fmem [256];
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic rd_pend = 1'b0;

    int cyc = 0;
    int rd_cnt = 0;
    int last_rd_cyc = 0;
    int consec = 0;
    logic rd_prev = 1'b0;
    int wv_cnt = 0;
    int rise_cyc = 0;
    logic wv_prev = 1'b0;

    int rd0, w0;

    rx_word_scheduler #(.TIMEOUT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .fifo_rd        (fifo_rd),
        .fifo_data      (fifo_data),
        .timeout_cycles (timeout_cycles),
        .word_data      (word_data),
        .word_bytes     (word_bytes),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .overrun        (overrun),
        .clear_overrun  (clear_overrun)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);

    // Read data appears the cycle after the strobe.
    always @(posedge clk) begin
        #1;
        if (rd_pend && (rd_ptr != wr_ptr)) begin
            fifo_data = fmem[rd_ptr[7:0]];
            rd_ptr++;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (fifo_rd) begin
            rd_cnt++;
            last_rd_cyc = cyc;
            if (rd_prev) consec++;
        end
        rd_prev = fifo_rd;
        rd_pend = fifo_rd;
        if (word_valid) wv_cnt++;
        if (word_valid && !wv_prev) rise_cyc = cyc;
        wv_prev = word_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fmem[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input int bound, input string tag);
        int n = 0;
        while (!word_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, word_valid}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; enable = 1'b0; fifo_full = 1'b0; word_ready = 1'b0;
        clear_overrun = 1'b0; timeout_cycles = 16'd0;
        #2;
        chk("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        chk("rst_valid", {31'd0, word_valid}, 32'd0);
        chk("rst_data", word_data, 32'd0);
        chk("rst_bytes", {29'd0, word_bytes}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        step(3);
        rst = 1'b1;

        // full word
        enable = 1'b1; word_ready = 1'b1;
        rd0 = rd_cnt; w0 = wv_cnt;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_valid(40, "t1_valid");
        chk("t1_data", word_data, 32'h44332211);
        chk("t1_bytes", {29'd0, word_bytes}, 32'd4);
        step(4);
        chk("t1_rd_pulses", rd_cnt - rd0, 32'd4);
        chk("t1_valid_cycles", wv_cnt - w0, 32'd1);

        // timeout flush: 10 idle cycles after the second LATCH, valid on the 11th
        timeout_cycles = 16'd10;
        push(8'hAA); push(8'hBB);
        wait_valid(60, "t2_valid");
        chk("t2_data", word_data, 32'h0000BBAA);
        chk("t2_bytes", {29'd0, word_bytes}, 32'd2);
        step(3);
        chk("t2_latency", rise_cyc - last_rd_cyc, 32'd12);
        timeout_cycles = 16'd0;

        // backpressure and overrun
        word_ready = 1'b0;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        wait_valid(40, "t3_valid");
        for (int i = 0; i < 20; i++) begin
            step(1);
            fifo_full = (i == 5);
            @(negedge clk);
            chk("t3_hold_data", word_data, 32'h04030201);
            chk("t3_hold_valid", {31'd0, word_valid}, 32'd1);
        end
        step(1);
        fifo_full = 1'b0;
        chk("t3_overrun_set", {31'd0, overrun}, 32'd1);
        clear_overrun = 1'b1;
        step(1);
        clear_overrun = 1'b0;
        @(negedge clk);
        chk("t3_overrun_clr", {31'd0, overrun}, 32'd0);
        step(1);
        fifo_full = 1'b1; clear_overrun = 1'b1;
        step(1);
        fifo_full = 1'b0; clear_overrun = 1'b0;
        @(negedge clk);
        chk("t3_set_wins", {31'd0, overrun}, 32'd1);
        step(1);
        clear_overrun = 1'b1;
        step(1);
        clear_overrun = 1'b0;
        word_ready = 1'b1;
        step(1);
        @(negedge clk);
        chk("t3_valid_drop", {31'd0, word_valid}, 32'd0);
        chk("t3_overrun_end", {31'd0, overrun}, 32'd0);

        // timeout disabled
        w0 = wv_cnt;
        push(8'h5A);
        step(1000);
        chk("t4_no_flush", wv_cnt - w0, 32'd0);
        chk("t4_partial", {29'd0, word_bytes}, 32'd1);
        push(8'h6B); push(8'h7C); push(8'h8D);
        wait_valid(40, "t4_valid");
        chk("t4_data", word_data, 32'h8D7C6B5A);
        chk("t4_bytes", {29'd0, word_bytes}, 32'd4);
        step(3);

        // enable gating
        enable = 1'b0;
        rd0 = rd_cnt;
        push(8'h10); push(8'h20); push(8'h30); push(8'h40);
        step(20);
        chk("t5_blocked", rd_cnt - rd0, 32'd0);
        enable = 1'b1; word_ready = 1'b0;
        wait_valid(40, "t5_valid");
        chk("t5_data", word_data, 32'h40302010);
        enable = 1'b0; word_ready = 1'b1;
        step(1);
        @(negedge clk);
        chk("t5_send_done", {31'd0, word_valid}, 32'd0);
        chk("t5_resumed", rd_cnt - rd0, 32'd4);

        // reset mid-word
        step(1);
        enable = 1'b1;
        push(8'hA1); push(8'hA2); push(8'hA3);
        step(10);
        chk("t6_three", {29'd0, word_bytes}, 32'd3);
        rst = 1'b0;
        #1;
        chk("t6_rst_data", word_data, 32'd0);
        chk("t6_rst_bytes", {29'd0, word_bytes}, 32'd0);
        chk("t6_rst_valid", {31'd0, word_valid}, 32'd0);
        push(8'hB1);
        #1;
        chk("t6_rst_rd", {31'd0, fifo_rd}, 32'd0);
        step(2);
        w0 = wv_cnt;
        rst = 1'b1;
        push(8'hB2); push(8'hB3); push(8'hB4);
        wait_valid(40, "t6_valid");
        chk("t6_data", word_data, 32'hB4B3B2B1);
        chk("t6_bytes", {29'd0, word_bytes}, 32'd4);
        step(3);
        chk("t6_one_word", wv_cnt - w0, 32'd1);

        chk("no_back_to_back_rd", consec, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
